// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue: entry layout, instruction size and mispredict rule.
// Pure declarations; no latency or backpressure of its own.
package br_pkg;
  localparam int BR_XLEN     = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [BR_XLEN-1:0] pc;
    logic               pred_take;
    logic [BR_XLEN-1:0] pred_target;
  } br_entry_t;

  // Target only matters when both sides agree the branch is taken.
  function automatic logic br_mispredict(input br_entry_t          e,
                                         input logic               res_taken,
                                         input logic [BR_XLEN-1:0] res_target);
    return (res_taken != e.pred_take) ||
           (res_taken && e.pred_take && (res_target != e.pred_target));
  endfunction
endpackage

// File: rtl/branch_resolve_queue_fifo.sv
// Circular FIFO with single-cycle clear; head visible combinationally, writes land next cycle.
// Caller gates push on not-full and pop on not-empty; clear wins over push/pop.
module br_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  T                       i_wdat,
  output T                       o_rdat,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T               r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdat;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_rdat  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/branch_resolve_queue.sv
// Holds in-flight branch predictions, trains the predictor and redirects fetch on mispredict.
// Update/redirect registered 1 cycle after resolve; enq_rdy from registered count, full drops enqueues.
module branch_resolve_queue
  import br_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = BR_XLEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq_vld,
  output logic                   enq_rdy,
  input  logic [XLEN-1:0]        enq_pc,
  input  logic                   enq_pred_take,
  input  logic [XLEN-1:0]        enq_pred_target,
  input  logic                   res_vld,
  input  logic                   res_taken,
  input  logic [XLEN-1:0]        res_target,
  input  logic                   flush,
  output logic [XLEN-1:0]        pc_past,
  output logic                   taken,
  output logic                   vld,
  output logic                   redirect_vld,
  output logic [XLEN-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);
  localparam int CW = $clog2(DEPTH) + 1;

  br_entry_t       w_head;
  br_entry_t       w_wdat;
  logic [CW-1:0]   w_count;
  logic            w_res_fire;
  logic            w_misp;
  logic            w_push;
  logic            w_clear;

  logic [XLEN-1:0] r_pc_past;
  logic            r_taken;
  logic            r_vld;
  logic            r_redirect_vld;
  logic [XLEN-1:0] r_redirect_pc;
  logic            r_err;

  assign w_res_fire = res_vld && (w_count != '0);
  assign w_misp     = w_res_fire && br_mispredict(w_head, res_taken, res_target);
  // Anything fetched alongside a mispredict or flush is on the wrong path.
  assign w_push     = enq_vld && enq_rdy && !flush && !w_misp;
  assign w_clear    = flush || w_misp;
  assign w_wdat     = '{pc: enq_pc, pred_take: enq_pred_take, pred_target: enq_pred_target};

  br_fifo #(.DEPTH(DEPTH), .T(br_entry_t)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_pop   (w_res_fire),
    .i_wdat  (w_wdat),
    .o_rdat  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_past      <= '0;
      r_taken        <= 1'b0;
      r_vld          <= 1'b0;
      r_redirect_vld <= 1'b0;
      r_redirect_pc  <= '0;
      r_err          <= 1'b0;
    end else begin
      r_vld          <= w_res_fire;
      r_redirect_vld <= w_misp;
      if (w_res_fire) begin
        r_pc_past <= w_head.pc;
        r_taken   <= res_taken;
      end
      if (w_misp) r_redirect_pc <= res_taken ? res_target : w_head.pc + XLEN'(INSTR_BYTES);
      if (res_vld && (w_count == '0)) r_err <= 1'b1;
    end
  end

  assign enq_rdy      = (w_count != CW'(DEPTH));
  assign count        = w_count;
  assign pc_past      = r_pc_past;
  assign taken        = r_taken;
  assign vld          = r_vld;
  assign redirect_vld = r_redirect_vld;
  assign redirect_pc  = r_redirect_pc;
  assign err          = r_err;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: queue-level reference model plus literal spot checks.
module tb_branch_resolve_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        enq_vld, enq_rdy, enq_pred_take;
  logic [31:0] enq_pc, enq_pred_target;
  logic        res_vld, res_taken;
  logic [31:0] res_target;
  logic        flush;
  logic [31:0] pc_past, redirect_pc;
  logic        taken, vld, redirect_vld, err;
  logic [2:0]  count;

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .enq_vld(enq_vld), .enq_rdy(enq_rdy), .enq_pc(enq_pc),
    .enq_pred_take(enq_pred_take), .enq_pred_target(enq_pred_target),
    .res_vld(res_vld), .res_taken(res_taken), .res_target(res_target),
    .flush(flush),
    .pc_past(pc_past), .taken(taken), .vld(vld),
    .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .count(count), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of outstanding predictions.
  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tg;
  } ent_t;

  ent_t        mq[$];
  bit          m_init = 0;
  logic        m_vld, m_taken, m_rv, m_err;
  logic [31:0] m_pc, m_rpc;

  always @(posedge clk) begin : model
    ent_t h;
    bit   mis;
    int   sz;
    if (rst) begin
      mq.delete();
      m_vld = 0; m_taken = 0; m_rv = 0; m_err = 0; m_pc = 0; m_rpc = 0;
      m_init = 1;
    end else begin
      sz = mq.size();
      m_vld = 0; m_rv = 0; mis = 0;
      if (res_vld) begin
        if (sz == 0) m_err = 1;
        else begin
          h = mq.pop_front();
          m_vld = 1; m_pc = h.pc; m_taken = res_taken;
          mis = (res_taken != h.pt) || (res_taken && h.pt && res_target != h.tg);
          if (mis) begin
            m_rv  = 1;
            m_rpc = res_taken ? res_target : h.pc + 32'd4;
            mq.delete();
          end
        end
      end
      if (enq_vld && sz < 4 && !flush && !mis) mq.push_back('{enq_pc, enq_pred_take, enq_pred_target});
      if (flush) mq.delete();
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_vld", {31'd0, vld}, {31'd0, m_vld});
      chk("m_taken", {31'd0, taken}, {31'd0, m_taken});
      chk("m_pc_past", pc_past, m_pc);
      chk("m_redirect_vld", {31'd0, redirect_vld}, {31'd0, m_rv});
      chk("m_redirect_pc", redirect_pc, m_rpc);
      chk("m_count", {29'd0, count}, mq.size());
      chk("m_enq_rdy", {31'd0, enq_rdy}, {31'd0, mq.size() != 4});
      chk("m_err", {31'd0, err}, {31'd0, m_err});
    end
  end

  task automatic idle();
    enq_vld = 0; enq_pc = 0; enq_pred_take = 0; enq_pred_target = 0;
    res_vld = 0; res_taken = 0; res_target = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_enq(input logic [31:0] pc, input logic pt, input logic [31:0] tg);
    enq_vld = 1; enq_pc = pc; enq_pred_take = pt; enq_pred_target = tg;
  endtask

  task automatic set_res(input logic t, input logic [31:0] tg);
    res_vld = 1; res_taken = t; res_target = tg;
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", {31'd0, vld}, 32'd0);
    chk("rst_redirect", {31'd0, redirect_vld}, 32'd0);
    chk("rst_pc_past", pc_past, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_enq_rdy", {31'd0, enq_rdy}, 32'd1);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 0;
    tick();

    // Correct taken prediction
    set_enq(32'h1111, 1, 32'h2000); tick();
    set_res(1, 32'h2000); tick();
    chk("ct_vld", {31'd0, vld}, 32'd1);
    chk("ct_pc_past", pc_past, 32'h1111);
    chk("ct_taken", {31'd0, taken}, 32'd1);
    chk("ct_redirect", {31'd0, redirect_vld}, 32'd0);
    chk("ct_count", {29'd0, count}, 32'd0);

    // Mispredict discards younger entries
    set_enq(32'h100, 0, 0); tick();
    set_enq(32'h104, 0, 0); tick();
    set_enq(32'h108, 0, 0); tick();
    set_res(1, 32'h400); tick();
    chk("mp_pc_past", pc_past, 32'h100);
    chk("mp_taken", {31'd0, taken}, 32'd1);
    chk("mp_redirect", {31'd0, redirect_vld}, 32'd1);
    chk("mp_redirect_pc", redirect_pc, 32'h400);
    chk("mp_count", {29'd0, count}, 32'd0);
    tick();
    chk("mp_vld_pulse", {31'd0, vld}, 32'd0);
    chk("mp_redirect_pulse", {31'd0, redirect_vld}, 32'd0);

    // Fill, drop an overflow enqueue, then drain
    for (int i = 0; i < 4; i++) begin
      set_enq(32'h200 + 32'(4 * i), 0, 0); tick();
    end
    chk("full_rdy", {31'd0, enq_rdy}, 32'd0);
    set_enq(32'h210, 0, 0); tick();
    chk("full_count", {29'd0, count}, 32'd4);
    set_res(0, 0); tick();
    chk("pop_count", {29'd0, count}, 32'd3);
    chk("pop_rdy", {31'd0, enq_rdy}, 32'd1);
    set_enq(32'h214, 0, 0); set_res(0, 0); tick();
    chk("swap_pc_past", pc_past, 32'h204);
    chk("swap_count", {29'd0, count}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      set_res(0, 0); tick();
    end
    chk("drain_pc_past", pc_past, 32'h214);
    chk("drain_count", {29'd0, count}, 32'd0);

    // Not-taken fall-through wraps
    set_enq(32'hFFFF_FFFC, 1, 32'h10); tick();
    set_res(0, 0); tick();
    chk("wrap_redirect_pc", redirect_pc, 32'h0);
    chk("wrap_taken", {31'd0, taken}, 32'd0);
    chk("wrap_redirect", {31'd0, redirect_vld}, 32'd1);

    // Taken with wrong target
    set_enq(32'h300, 1, 32'h500); tick();
    set_res(1, 32'h600); tick();
    chk("tgt_redirect_pc", redirect_pc, 32'h600);
    chk("tgt_redirect", {31'd0, redirect_vld}, 32'd1);

    // Mispredict with same-cycle enqueue
    set_enq(32'h700, 0, 0); tick();
    set_enq(32'h704, 0, 0); set_res(1, 32'h800); tick();
    chk("mpenq_count", {29'd0, count}, 32'd0);

    // Resolve on empty sets sticky err
    set_res(0, 0); tick();
    chk("empty_vld", {31'd0, vld}, 32'd0);
    chk("empty_err", {31'd0, err}, 32'd1);
    tick();
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Flush with simultaneous correct resolve and enqueue
    set_enq(32'h900, 0, 0); tick();
    set_enq(32'h904, 0, 0); tick();
    set_enq(32'h908, 0, 0); set_res(0, 0); flush = 1; tick();
    chk("fl_vld", {31'd0, vld}, 32'd1);
    chk("fl_pc_past", pc_past, 32'h900);
    chk("fl_redirect", {31'd0, redirect_vld}, 32'd0);
    chk("fl_count", {29'd0, count}, 32'd0);

    // Reset mid-operation suppresses the pending update
    set_enq(32'hA00, 0, 0); tick();
    rst = 1; set_res(0, 0); tick();
    chk("mrst_vld", {31'd0, vld}, 32'd0);
    chk("mrst_count", {29'd0, count}, 32'd0);
    chk("mrst_err", {31'd0, err}, 32'd0);
    rst = 0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Tracks in-flight conditional-branch predictions between fetch and execute. When execute resolves each branch, the queue compares the outcome against the stored prediction. It then drives the training interface of the branch predictor (`pc_past`/`taken`/`vld`) and raises a one-cycle redirect on a mispredict. It sits between the fetch-stage predictor lookup and the execute-stage branch unit, and is the producer end of the predictor's update port.

## Interface
- `DEPTH`, 4: number of in-flight branch entries; power of two, ≥2.
- `XLEN`, 32: PC width.

- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `enq_vld` in 1: fetch is issuing a predicted branch this cycle.
- `enq_rdy` out 1: queue can accept an entry; equals `count != DEPTH`.
- `enq_pc` in XLEN: branch PC.
- `enq_pred_take` in 1: predictor's `predict_take` for this branch.
- `enq_pred_target` in XLEN: predicted target; only meaningful when `enq_pred_take`=1.
- `res_vld` in 1: execute resolves the oldest outstanding branch. Resolutions arrive in program order.
- `res_taken` in 1: actual direction.
- `res_target` in XLEN: actual taken target.
- `flush` in 1: external pipeline flush (exception/trap); discards all entries.
- `pc_past` out XLEN: update PC to the predictor.
- `taken` out 1: update direction.
- `vld` out 1: update strobe, one cycle per resolved branch.
- `redirect_vld` out 1: mispredict strobe.
- `redirect_pc` out XLEN: correct next PC.
- `count` out $clog2(DEPTH)+1: occupied entries.
- `err` out 1: sticky; set when a resolution arrives while the queue is empty.

## Operation
- Enqueue: when `enq_vld && enq_rdy`, write {pc, pred_take, pred_target} at the tail. If `enq_vld` is high while full, the entry is dropped; holding `enq_vld` until `enq_rdy` is fetch's job.
- Resolve: when `res_vld` and `count>0`:
  - Pop the head entry.
  - Register `pc_past`=head.pc, `taken`=`res_taken`, `vld`=1.
- Mispredict occurs if either condition holds:
  - `res_taken != head.pred_take`; or
  - both `res_taken` and `head.pred_take` are set and `res_target != head.pred_target`.
- On mispredict:
  - `redirect_vld`=1.
  - `redirect_pc` = `res_taken` ? `res_target` : head.pc + 4, modulo 2^XLEN; 0xFFFFFFFC wraps to 0.
  - All remaining entries are discarded (wrong path).
  - An enqueue in the same cycle is discarded.
- Correct prediction: `redirect_vld`=0. The queue retains the younger entries. A simultaneous enqueue is accepted, and the net count is unchanged.
- `res_vld` with `count==0`: no update, no redirect, `err`←1.
- `flush`: all entries cleared the next cycle, and any same-cycle enqueue is discarded. A same-cycle resolve still emits its predictor update and any redirect; training is never lost.
- `rst` overrides everything. Mid-operation it discards entries and suppresses any pending update or redirect.

## Timing
- Reset values: `vld`=0, `taken`=0, `pc_past`=0, `redirect_vld`=0, `redirect_pc`=0, `count`=0, `enq_rdy`=1, `err`=0.
- Update and redirect latency: 1 cycle after the `res_vld` edge, both registered. `vld`/`redirect_vld` are high for exactly one cycle; `pc_past`/`taken` hold until the next update.
- `enq_rdy` derives from registered `count` only, with no combinational path from `res_vld`. A pop from full frees a slot the following cycle.
- Head/tail pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty is decided by `count`.
- Back-to-back resolves at one per cycle are supported.

## Structure
- Package `br_pkg` holds:
  - `br_entry_t` struct {pc, pred_take, pred_target};
  - `INSTR_BYTES`=4;
  - a mispredict helper function.
- Sub-module `br_fifo`: a synchronous circular FIFO with a single-cycle `clear`, parameterized on `DEPTH` and entry type. The top level contains the compare, redirect and update registers.

## Test plan
- Reset: assert `rst` for 2 cycles → all outputs at reset values, `enq_rdy`=1.
- Correct taken: enq pc 0x1111, pred 1, target 0x2000; res taken=1, target 0x2000 → next cycle `vld`=1, `pc_past`=0x1111, `taken`=1, `redirect_vld`=0, `count`=0.
- Mispredict flush: enq 0x100 (pred 0), 0x104, 0x108; res taken=1, target 0x400 → `pc_past`=0x100, `taken`=1, `redirect_vld`=1, `redirect_pc`=0x400, `count`=0.
- Full/backpressure: 4 enqueues → `enq_rdy`=0, a 5th is ignored (`count`=4); one correct resolve → `count`=3, `enq_rdy`=1 next cycle.
- Not-taken wrap: enq 0xFFFFFFFC, pred 1; res taken=0 → `redirect_pc`=0x0, `taken`=0.
- Empty resolve then flush: res on empty → `vld`=0, `err`=1 and stays set; enq 2 entries + `flush` with a simultaneous correct resolve → one update emitted, `count`=0.
